// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - Shares one single-ported memory between fetch and data requesters.
// Data has priority; fetch is forced after MAX_DEFER consecutive data wins over it.
module unified_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 2,
  parameter int MAX_DEFER = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int DEF_W = $clog2(MAX_DEFER + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [DEF_W-1:0] DEF_MAX  = DEF_W'(MAX_DEFER);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic [DEF_W-1:0] defer_cnt;
  logic             own_d;
  logic             we_q;
  logic             sel_d, sel_f;

  assign sel_d = d_req && (!if_req || defer_cnt < DEF_MAX);
  assign sel_f = !sel_d && if_req;
  assign stall = if_req & ~if_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_d || sel_f) state_nxt = ACCESS;
      ACCESS:  if (lat_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      defer_cnt <= '0;
      own_d     <= 1'b0;
      we_q      <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_d || sel_f) begin
            own_d     <= sel_d;
            we_q      <= sel_d & d_we;
            mem_we    <= sel_d & d_we;
            mem_en    <= 1'b1;
            mem_addr  <= sel_d ? d_addr : if_addr;
            mem_wdata <= sel_d ? d_wdata : '0;
            lat_cnt   <= LAT_INIT;
            if_gnt    <= sel_f;
            d_gnt     <= sel_d;
            if (sel_f)
              defer_cnt <= '0;
            else if (if_req && defer_cnt < DEF_MAX)
              defer_cnt <= defer_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            mem_en <= 1'b0;
            if (own_d) begin
              d_valid <= 1'b1;
              d_rdata <= we_q ? '0 : mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - Self-checking bench for unified_mem_arbiter.
module tb_unified_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req1;
  logic [31:0] if_addr1;
  logic        if_gnt1, if_valid1, d_gnt1, d_valid1, mem_en1, mem_we1, stall1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        d_req1 = 1'b0, d_we1 = 1'b0;
  logic [31:0] d_addr1 = '0, d_wdata1 = '0;
  logic [31:0] mem_rdata1 = 32'hA5A50001;

  always #5 clock = ~clock;

  unified_mem_arbiter #(.MEM_LAT(2), .MAX_DEFER(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  unified_mem_arbiter #(.MEM_LAT(1), .MAX_DEFER(4)) dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rdata(if_rdata1), .if_valid(if_valid1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rdata(d_rdata1), .d_valid(d_valid1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall(stall1)
  );

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clock) if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic is_d; logic [31:0] rdata; } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (if_valid || d_valid)) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {if_valid, d_valid}, 2'b00);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("valid_owner", d_valid, e.is_d);
        check("rdata", d_valid ? d_rdata : if_rdata, e.rdata);
      end
    end
  end

  // Caller is positioned just after a negedge; request is sampled at the next posedge.
  task automatic do_txn(input vec_t v);
    int gnt_cyc = 0, val_cyc = 0, en_cnt = 0, we_cnt = 0;
    sb_t e;
    e.is_d = v.is_d;
    e.rdata = v.exp_rdata;
    sb.push_back(e);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
      if (v.is_d ? d_gnt : if_gnt) begin
        gnt_cyc = c;
        check("gnt_addr", mem_addr, v.addr);
        if (v.we) check("gnt_wdata", mem_wdata, v.wdata);
        if (!v.is_d) check("stall_pending", stall, 1'b1);
      end
      if (v.is_d ? d_valid : if_valid) begin
        val_cyc = c;
        if (!v.is_d) check("stall_done", stall, 1'b0);
        break;
      end
    end
    check("gnt_latency", gnt_cyc, 1);
    check("valid_latency", val_cyc, 3);
    check("mem_en_cycles", en_cnt, 2);
    check("mem_we_cycles", we_cnt, v.we ? 1 : 0);
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_d;
    logic [1:0] st;
    int k, cnt;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'h3C010003;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h3C010003};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b1, 32'h80, 32'h12345678, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h80, 32'h0,        32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'h3C010003};

    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req1 = 1'b0; if_addr1 = '0;
    @(negedge clock);
    @(negedge clock);
    check("reset_outputs", {if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we}, 6'b0);
    check("reset_stall", stall, 1'b1);
    reset = 1'b0;
    do_txn(vecs[0]);

    for (int i = 1; i < 7; i++) do_txn(vecs[i]);

    // Contention: both held, data re-requests immediately.
    exp_d = 10'b0111101111;
    k = 0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 0; c < 200 && k < 10; c++) begin
      @(negedge clock);
      if (if_gnt || d_gnt) begin
        sb_t e;
        check("contention_owner", d_gnt, exp_d[k]);
        e.is_d = exp_d[k];
        e.rdata = exp_d[k] ? 32'hDEADBEEF : 32'h3C010003;
        sb.push_back(e);
        if (!exp_d[k]) check("defer_cleared", dut.defer_cnt, 0);
        k++;
      end
    end
    check("contention_grants", k, 10);
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge clock);

    // Reset on the second ACCESS cycle of a load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clock);
    check("abort_gnt", d_gnt, 1'b1);
    @(negedge clock);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clock);
    st = dut.state;
    check("abort_mem_en", mem_en, 1'b0);
    check("abort_state", st, 2'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (d_valid) cnt++;
    end
    check("abort_no_valid", cnt, 0);

    // MEM_LAT=1 instance.
    begin
      int gnt_cyc = 0, val_cyc = 0, en_cnt = 0;
      if_req1 = 1'b1; if_addr1 = 32'h20;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clock);
        if (mem_en1) en_cnt++;
        if (if_gnt1) gnt_cyc = c;
        if (if_valid1) begin
          val_cyc = c;
          check("lat1_rdata", if_rdata1, 32'hA5A50001);
          break;
        end
      end
      if_req1 = 1'b0;
      check("lat1_gnt", gnt_cyc, 1);
      check("lat1_valid", val_cyc, 2);
      check("lat1_mem_en", en_cnt, 1);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
